prio_encoder_rr: RTL and testbench
==================================

PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 Parameter N, default 8: number of request inputs, 2..64.
REQ-002 Parameter W, default 3: index width, SHALL equal ceil(log2(N)).
REQ-003 clk  input  1  rising-edge clock; all state updates on posedge clk only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 din  input  N  request vector; bit i set = request on channel i.
REQ-006 en  input  1  arbitration enable; no new grant is issued while low.
REQ-007 mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-008 ack  input  1  consumer acknowledge of the current grant.
REQ-009 dout  output  W  binary index of granted channel, registered.
REQ-010 grant  output  N  one-hot grant vector, registered; bit dout set while valid.
REQ-011 valid  output  1  registered; high while a grant is held.

Function
REQ-012 Two states, IDLE and HOLD; reset state IDLE.
REQ-013 IDLE: at a posedge with en=1 and |din=1, the block SHALL latch the winner into dout/grant, set valid=1 and enter HOLD; outputs visible after that same edge (1-cycle latency).
REQ-014 IDLE with en=0 or din=0: no state change; valid stays 0; grant stays 0; dout holds its last value.
REQ-015 mode=0 winner: highest set index of din (din=8'b1000_0001 -> 7).
REQ-016 mode=1 winner: first set bit searching upward from pointer ptr (W bits), wrapping from N-1 to 0.
REQ-017 ptr SHALL change only on grant completion in mode=1: ptr <= (dout+1) mod N, wrapping N-1 -> 0; mode=0 completion leaves ptr unchanged.
REQ-018 mode is sampled at the arbitration edge for winner selection and at the ack edge for the ptr update.
REQ-019 HOLD: dout, grant and valid SHALL remain stable regardless of din, en or mode changes until ack.
REQ-020 HOLD with ack=1 at a posedge: valid <= 0, grant <= 0, ptr updated per REQ-017, return to IDLE; dout keeps granted index.
REQ-021 ack while in IDLE (valid=0) SHALL be ignored.
REQ-022 Minimum spacing between grants: one IDLE cycle; ack at edge m permits the next arbitration no earlier than edge m+1.
REQ-023 grant SHALL always be zero or one-hot; when valid=1, grant == (1 << dout).
REQ-024 For N not a power of two, ptr and dout SHALL never exceed N-1.

Reset
REQ-025 rst=1 at a posedge SHALL force: state IDLE, dout=0, grant=0, valid=0, ptr=0.
REQ-026 rst SHALL take priority over ack, en and din in the same cycle, including during HOLD (grant discarded, no ptr update).
REQ-027 First arbitration after reset is possible at the first edge with rst=0.

Verification (N=8)
REQ-028 mode=0, en=1, din=8'b1000_0001 after reset -> next cycle valid=1, dout=7, grant=8'h80; held until ack.
REQ-029 mode=1, ptr=0, din held 8'b1000_0001 with ack one cycle after each valid -> dout sequence 0, 7, 0, 7 (ptr 1, 0, 1, 0).
REQ-030 In HOLD with dout=3, change din to 8'h80 and toggle mode -> dout=3, grant=8'h08 unchanged until ack.
REQ-031 din=8'h00, en=1, or din=8'hFF, en=0, for 10 cycles -> valid=0, grant=0 throughout.
REQ-032 mode=1, dout=5 held, assert rst and ack together -> next cycle valid=0, dout=0, ptr=0; then din=8'h20 -> dout=5.
REQ-033 Single ack pulse while IDLE, then din=8'h04 -> valid=1, dout=2, ptr unaffected by the stray ack.

Source files
------------

// File: rtl/prio_encoder_rr_if.sv
// Request/grant bundle between a requester and the priority encoder.
// The master side drives requests and acknowledges; the slave side returns the grant.
interface prio_encoder_rr_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
);
  logic [N-1:0] din;
  logic         en;
  logic         mode;
  logic         ack;
  logic [W-1:0] dout;
  logic [N-1:0] grant;
  logic         valid;

  modport master (output din, en, mode, ack, input dout, grant, valid);
  modport slave  (input din, en, mode, ack, output dout, grant, valid);
endinterface

// File: rtl/prio_encoder_rr.sv
// Fixed-priority / round-robin arbiter that latches one grant and holds it until ack.
// W must equal ceil(log2(N)).
module prio_encoder_rr #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic             clk,
  input  logic             rst,
  prio_encoder_rr_if.slave bus
);

  localparam int unsigned WP = W + 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] dout_q, dout_d;
  logic [N-1:0] grant_q, grant_d;
  logic         valid_q, valid_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [W-1:0]   fixed_win_c;
  logic [W-1:0]   rr_win_c;
  logic [W-1:0]   win_c;
  logic [W-1:0]   ptr_inc_c;
  logic [2*N-1:0] dbl_c;
  logic [N-1:0]   rot_c;
  logic [W-1:0]   rr_off_c;
  logic           rr_hit_c;
  logic [WP-1:0]  rr_sum_c;

  // Fixed priority: highest set index wins.
  always_comb begin
    fixed_win_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (bus.din[i]) fixed_win_c = W'(i);
    end
  end

  // Round robin: rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl_c    = {bus.din, bus.din};
    rot_c    = N'(dbl_c >> ptr_q);
    rr_off_c = '0;
    rr_hit_c = 1'b0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (rot_c[j]) begin
        rr_off_c = W'(j);
        rr_hit_c = 1'b1;
      end
    end
    rr_sum_c = WP'(ptr_q) + WP'(rr_off_c);
    if (rr_sum_c >= WP'(N)) rr_sum_c = rr_sum_c - WP'(N);
    rr_win_c = rr_hit_c ? W'(rr_sum_c) : '0;
  end

  assign win_c     = bus.mode ? rr_win_c : fixed_win_c;
  assign ptr_inc_c = (dout_q == W'(N - 1)) ? '0 : dout_q + W'(1);

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.en && (|bus.din)) begin
          dout_d  = win_c;
          grant_d = N'(1) << win_c;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.ack) begin
          valid_d = 1'b0;
          grant_d = '0;
          state_d = IDLE;
          if (bus.mode) ptr_d = ptr_inc_c;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.grant = grant_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr (N=8) with a per-cycle reference model.
module tb_prio_encoder_rr;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  prio_encoder_rr_if #(.N(N), .W(W)) bus ();
  prio_encoder_rr #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model state
  bit           m_hold;
  bit           m_valid;
  int           m_dout;
  int           m_ptr;
  logic [N-1:0] m_grant;
  bit           started;

  function automatic int pick(logic [N-1:0] d, bit rr, int p);
    int w = 0;
    if (!rr) begin
      for (int i = 0; i < int'(N); i++) if (d[i]) w = i;
    end else begin
      for (int k = int'(N) - 1; k >= 0; k--) if (d[(p + k) % int'(N)]) w = (p + k) % int'(N);
    end
    return w;
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_hold <= 0; m_valid <= 0; m_dout <= 0; m_grant <= '0; m_ptr <= 0;
    end else if (m_hold) begin
      if (bus.ack) begin
        m_hold <= 0; m_valid <= 0; m_grant <= '0;
        if (bus.mode) m_ptr <= (m_dout + 1) % int'(N);
      end
    end else if (bus.en && bus.din != '0) begin
      m_dout  <= pick(bus.din, bus.mode, m_ptr);
      m_grant <= '0;
      m_grant[pick(bus.din, bus.mode, m_ptr)] <= 1'b1;
      m_valid <= 1; m_hold <= 1;
    end
  end

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("model_valid", longint'(bus.valid), longint'(m_valid));
      check("model_dout",  longint'(bus.dout),  longint'(m_dout));
      check("model_grant", longint'(bus.grant), longint'(m_grant));
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, bit v, int d, int g);
    check({name, "_valid"}, longint'(bus.valid), longint'(v));
    check({name, "_dout"},  longint'(bus.dout),  longint'(d));
    check({name, "_grant"}, longint'(bus.grant), longint'(g));
  endtask

  int rr_seq [4] = '{0, 7, 0, 7};

  initial begin
    rst = 1'b1;
    bus.din = '0; bus.en = 0; bus.mode = 0; bus.ack = 0;
    step(2);
    chk("reset", 0, 0, 'h00);
    rst = 1'b0;

    // Fixed priority, highest index wins, held until ack
    bus.mode = 0; bus.en = 1; bus.din = 8'b1000_0001;
    step(1); chk("fixed_grant", 1, 7, 'h80);
    bus.en = 0; bus.din = '0;
    step(3); chk("fixed_hold", 1, 7, 'h80);
    bus.ack = 1;
    step(1); chk("fixed_ack", 0, 7, 'h00);
    bus.ack = 0;

    // Round robin alternation with ptr wrapping 7 -> 0
    bus.mode = 1; bus.en = 1; bus.din = 8'b1000_0001;
    for (int s = 0; s < 4; s++) begin
      bus.ack = 0;
      step(1); chk($sformatf("rr_seq%0d", s), 1, rr_seq[s], 1 << rr_seq[s]);
      bus.ack = 1;
      step(1); chk($sformatf("rr_rel%0d", s), 0, rr_seq[s], 'h00);
    end
    bus.ack = 0;

    // HOLD is immune to din/mode/en changes
    bus.mode = 0; bus.din = 8'h08;
    step(1); chk("hold_grant", 1, 3, 'h08);
    bus.din = 8'h80; bus.mode = 1;
    step(2); chk("hold_mode1", 1, 3, 'h08);
    bus.mode = 0; bus.din = 8'hFF; bus.en = 0;
    step(1); chk("hold_mode0", 1, 3, 'h08);
    bus.ack = 1;
    step(1); chk("hold_ack", 0, 3, 'h00);
    bus.ack = 0;

    // No grant with empty requests or enable low
    bus.din = 8'h00; bus.en = 1;
    for (int c = 0; c < 10; c++) begin step(1); chk("no_req", 0, 3, 'h00); end
    bus.din = 8'hFF; bus.en = 0;
    for (int c = 0; c < 10; c++) begin step(1); chk("no_en", 0, 3, 'h00); end

    // Reset beats ack during HOLD
    bus.mode = 1; bus.din = 8'h20; bus.en = 1;
    step(1); chk("pre_rst", 1, 5, 'h20);
    bus.en = 0;
    step(1);
    rst = 1; bus.ack = 1;
    step(1); chk("rst_hold", 0, 0, 'h00);
    rst = 0; bus.ack = 0; bus.en = 1;
    step(1); chk("post_rst", 1, 5, 'h20);
    bus.en = 0; bus.ack = 1;
    step(1); chk("post_rst_ack", 0, 5, 'h00);
    // ptr now 6: search 6,7,0 picks channel 0 over channel 5
    bus.ack = 0; bus.din = 8'h21; bus.en = 1;
    step(1); chk("rr_from6", 1, 0, 'h01);
    bus.en = 0; bus.ack = 1;
    step(1); chk("rr_from6_ack", 0, 0, 'h00);

    // Stray ack in IDLE is ignored; ptr stays 1, so channel 2 beats channel 0
    step(1); chk("stray_ack", 0, 0, 'h00);
    bus.ack = 0;
    step(1);
    bus.din = 8'h05; bus.en = 1;
    step(1); chk("after_stray", 1, 2, 'h04);
    bus.en = 0; bus.ack = 1;
    step(1); bus.ack = 0;
    bus.din = 8'h04; bus.en = 1;
    step(1); chk("spec_stray", 1, 2, 'h04);
    bus.en = 0; bus.ack = 1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
